// File: rtl/fxp_mac_sat.sv
// Pipelined signed fixed-point MAC with output rounding and saturation.
// Optional macro FXP_MAC_ROUND_EN selects round-half-up instead of floor.
module fxp_mac_sat #(
  parameter int WIDTH = 25,
  parameter int FRAC  = 16,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             first,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam int RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] MAXV =
    {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV =
    {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic                    en;
  logic                    v1;
  logic                    f1;
  logic                    l1;
  logic signed [PW-1:0]    p_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [RW-1:0]    rw;
  logic signed [RW-1:0]    rs;
  logic [WIDTH-1:0]        ysat;
  logic                    sat;
  logic                    fire;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign fire     = en && v1 && l1;

  assign acc_base = f1 ? '0 : acc_reg;
  assign acc_next = acc_base + {{GUARD{p_reg[PW-1]}}, p_reg};

`ifdef FXP_MAC_ROUND_EN
  localparam logic [RW-1:0] HALF =
    {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);
  // one extra bit so the half-LSB add cannot wrap
  assign rw = {acc_next[ACC_W-1], acc_next} + HALF;
`else
  assign rw = {acc_next[ACC_W-1], acc_next};
`endif

  assign rs = rw >>> FRAC;

  always_comb begin
    sat  = 1'b0;
    ysat = rs[WIDTH-1:0];
    if (rs > MAXV) begin
      sat  = 1'b1;
      ysat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (rs < MINV) begin
      sat  = 1'b1;
      ysat = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      f1         <= 1'b0;
      l1         <= 1'b0;
      p_reg      <= '0;
      acc_reg    <= '0;
      out_valid  <= 1'b0;
      y          <= '0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (clr_sticky)
        ovf_sticky <= 1'b0;
      if (fire && sat)
        ovf_sticky <= 1'b1;
      if (en) begin
        v1        <= in_valid;
        out_valid <= v1 && l1;
        if (in_valid) begin
          p_reg <= PW'($signed(a)) * PW'($signed(b));
          f1    <= first;
          l1    <= last;
        end
        if (v1) begin
          if (l1) begin
            acc_reg <= '0;
            y       <= ysat;
            out_ovf <= sat;
          end else begin
            acc_reg <= acc_next;
          end
        end
      end
    end
  end

endmodule
